// File: rtl/waveform_pkg.sv
// Shared waveform RAM geometry and loader state encoding, used by the loader,
// the oscillator and the RAM instance.
package waveform_pkg;

  localparam int SAMPLE_WIDTH    = 24;
  localparam int WAVE_DEPTH      = 512;
  localparam int WAVE_ADDR_WIDTH = $clog2(WAVE_DEPTH);
  localparam int BPS             = SAMPLE_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    CHECK,
    DONE
  } loader_state_t;

endpackage

// File: rtl/waveform_loader_if.sv
// Byte-stream input and waveform RAM port A bundle for the waveform loader.
interface waveform_loader_if;
  import waveform_pkg::*;

  logic [7:0]                 byte_in;
  logic                       byte_valid_in;
  logic                       byte_ready_out;
  logic [WAVE_ADDR_WIDTH-1:0] ram_addr_out;
  logic [SAMPLE_WIDTH-1:0]    ram_din_out;
  logic                       ram_we_out;
  logic                       ram_en_out;

  modport slave (
    input  byte_in, byte_valid_in,
    output byte_ready_out, ram_addr_out, ram_din_out, ram_we_out, ram_en_out
  );

  modport master (
    output byte_in, byte_valid_in,
    input  byte_ready_out, ram_addr_out, ram_din_out, ram_we_out, ram_en_out
  );

endinterface

// File: rtl/byte_assembler.sv
// Packs accepted bytes MSB-first into a WIDTH-bit word; word_complete flags the
// acceptance of the final byte, after which the counter restarts at zero.
module byte_assembler #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             accept,
  input  logic [7:0]       byte_in,
  output logic [WIDTH-1:0] word,
  output logic             word_complete
);

  localparam int NBYTES = WIDTH / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign word          = shift_q;
  assign word_complete = accept && (cnt_q == LAST_BYTE);

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (accept) begin
      shift_d = (shift_q << 8) | WIDTH'(byte_in);
      cnt_d   = word_complete ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/waveform_loader.sv
// Streams bytes into the waveform RAM, one full table per load.
// Optional trailing XOR checksum byte when WAVE_LOADER_CHECKSUM_EN is defined.
module waveform_loader
  import waveform_pkg::*;
(
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   start_in,
  input  logic                   abort_in,
  waveform_loader_if.slave       bus,
  output logic                   busy_out,
  output logic                   done_out,
  output logic [WAVE_ADDR_WIDTH:0] sample_count_out,
  output logic                   error_out
);

  localparam logic [WAVE_ADDR_WIDTH-1:0] LAST_IDX = WAVE_ADDR_WIDTH'(WAVE_DEPTH - 1);

  loader_state_t              state_q, state_d;
  logic [WAVE_ADDR_WIDTH-1:0] idx_q, idx_d, addr_q, addr_d;
  logic [SAMPLE_WIDTH-1:0]    din_q, din_d, asm_word;
  logic [WAVE_ADDR_WIDTH:0]   count_q, count_d;
  logic                       asm_clear, asm_accept, word_complete, in_write;
`ifdef WAVE_LOADER_CHECKSUM_EN
  logic [7:0]                 csum_q, csum_d;
  logic                       err_q, err_d;
`endif

  byte_assembler #(.WIDTH(SAMPLE_WIDTH)) u_asm (
    .clk           (clk_in),
    .rst_n         (rst_n_in),
    .clear         (asm_clear),
    .accept        (asm_accept),
    .byte_in       (bus.byte_in),
    .word          (asm_word),
    .word_complete (word_complete)
  );

  assign in_write   = (state_q == WRITE);
  assign asm_accept = bus.byte_valid_in && (state_q == RECV);

`ifdef WAVE_LOADER_CHECKSUM_EN
  assign bus.byte_ready_out = (state_q == RECV) || (state_q == CHECK);
  assign error_out          = err_q;
`else
  assign bus.byte_ready_out = (state_q == RECV);
  assign error_out          = 1'b0;
`endif

  // Address/data hold their last written values so only the strobe qualifies.
  assign bus.ram_we_out   = in_write;
  assign bus.ram_en_out   = in_write;
  assign bus.ram_addr_out = in_write ? idx_q : addr_q;
  assign bus.ram_din_out  = in_write ? asm_word : din_q;

  assign busy_out         = (state_q != IDLE);
  assign done_out         = (state_q == DONE);
  assign sample_count_out = count_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    addr_d    = addr_q;
    din_d     = din_q;
    asm_clear = 1'b0;
`ifdef WAVE_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_in) begin
          idx_d     = '0;
          count_d   = '0;
          asm_clear = 1'b1;
`ifdef WAVE_LOADER_CHECKSUM_EN
          csum_d    = '0;
          err_d     = 1'b0;
`endif
          state_d   = RECV;
        end
      end
      RECV: begin
`ifdef WAVE_LOADER_CHECKSUM_EN
        if (asm_accept) csum_d = csum_q ^ bus.byte_in;
`endif
        if (abort_in)           state_d = IDLE;
        else if (word_complete) state_d = WRITE;
      end
      WRITE: begin
        addr_d  = idx_q;
        din_d   = asm_word;
        count_d = count_q + 1'b1;
        if (abort_in) begin
          state_d = IDLE;
        end else if (idx_q == LAST_IDX) begin
`ifdef WAVE_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = RECV;
        end
      end
`ifdef WAVE_LOADER_CHECKSUM_EN
      CHECK: begin
        if (abort_in) begin
          state_d = IDLE;
        end else if (bus.byte_valid_in) begin
          if (bus.byte_in != csum_q) err_d = 1'b1;
          state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      count_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
`ifdef WAVE_LOADER_CHECKSUM_EN
      csum_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
`ifdef WAVE_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_waveform_loader.sv
// Scoreboard bench for waveform_loader: stimulus pushes expected RAM writes and
// status checks into queues, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_waveform_loader;
  import waveform_pkg::*;

  logic clk, rst_n, start, abort;
  logic busy, done, err;
  logic [WAVE_ADDR_WIDTH:0] cnt;

  waveform_loader_if bus();

  waveform_loader dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .start_in         (start),
    .abort_in         (abort),
    .bus              (bus),
    .busy_out         (busy),
    .done_out         (done),
    .sample_count_out (cnt),
    .error_out        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WAVE_ADDR_WIDTH-1:0] addr;
    logic [SAMPLE_WIDTH-1:0]    din;
  } wr_t;

  typedef enum int {K_ZERO, K_WE, K_BUSY, K_COUNT, K_ERR, K_DONES, K_PENDING} kind_t;

  typedef struct {
    kind_t       kind;
    logic [63:0] exp;
    string       name;
  } chk_t;

  wr_t  wq[$];
  chk_t cq[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   done_seen = 0;
  int   exp_dones = 0;

  function automatic logic [63:0] actual_of(kind_t k);
    case (k)
      K_ZERO:    return 64'({bus.byte_ready_out, bus.ram_we_out, bus.ram_en_out, done, busy,
                             err, cnt, bus.ram_addr_out, bus.ram_din_out});
      K_WE:      return 64'(bus.ram_we_out);
      K_BUSY:    return 64'(busy);
      K_COUNT:   return 64'(cnt);
      K_ERR:     return 64'(err);
      K_DONES:   return 64'(done_seen);
      K_PENDING: return 64'(wq.size());
      default:   return '1;
    endcase
  endfunction

  // Monitor: compares every write strobe and every queued status check.
  initial begin
    wr_t         w;
    chk_t        c;
    logic [63:0] a;
    forever begin
      @(negedge clk);
      if (bus.ram_we_out) begin
        n_checks++;
        if (wq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: addr=%0d din=%h, required no write", bus.ram_addr_out, bus.ram_din_out);
        end else begin
          w = wq.pop_front();
          if (bus.ram_addr_out !== w.addr || bus.ram_din_out !== w.din || bus.ram_en_out !== 1'b1) begin
            n_fail++;
            $display("FAIL ram_write: got addr=%0d din=%h en=%b, required addr=%0d din=%h en=1",
                     bus.ram_addr_out, bus.ram_din_out, bus.ram_en_out, w.addr, w.din);
          end
        end
      end
      if (done) done_seen++;
      while (cq.size() > 0) begin
        c = cq.pop_front();
        a = actual_of(c.kind);
        n_checks++;
        if (a !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got %0h, required %0h", c.name, a, c.exp);
        end
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_val(input kind_t k, input logic [63:0] e, input string nm);
    chk_t c;
    c.kind = k;
    c.exp  = e;
    c.name = nm;
    cq.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      while ($urandom_range(0, 9) < 3) step();
    end
    bus.byte_in       = b;
    bus.byte_valid_in = 1'b1;
    t = 0;
    while (!bus.byte_ready_out && t < 200) begin
      step();
      t++;
    end
    step();
    bus.byte_valid_in = 1'b0;
  endtask

  function automatic logic [7:0] pay(input int mode, input int k);
    return (mode == 0) ? 8'(k % 256) : 8'hAA;
  endfunction

  task automatic push_sample(input int mode, input int i);
    wr_t w;
    w.addr = WAVE_ADDR_WIDTH'(i);
    w.din  = {pay(mode, 3*i), pay(mode, 3*i+1), pay(mode, 3*i+2)};
    wq.push_back(w);
  endtask

  task automatic send_sample(input int mode, input int i, input bit gaps);
    push_sample(mode, i);
    for (int j = 0; j < BPS; j++) send_byte(pay(mode, BPS*i + j), gaps);
  endtask

  task automatic load_data(input int mode, input bit gaps);
    pulse_start();
    for (int i = 0; i < WAVE_DEPTH; i++) send_sample(mode, i, gaps);
  endtask

  task automatic finish_load(input int exp_cnt, input logic exp_err, input string nm);
    int t;
    t = 0;
    while (busy && t < 100) begin
      step();
      t++;
    end
    exp_dones++;
    expect_val(K_BUSY,  64'd0,            {nm, "_busy"});
    expect_val(K_COUNT, 64'(exp_cnt),     {nm, "_count"});
    expect_val(K_DONES, 64'(exp_dones),   {nm, "_done_pulses"});
    expect_val(K_ERR,   64'(exp_err),     {nm, "_error"});
    step();
  endtask

  initial begin
    wr_t w;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    bus.byte_in       = 8'h00;
    bus.byte_valid_in = 1'b0;
    repeat (3) step();
    expect_val(K_ZERO, 64'd0, "reset_outputs");
    step();
    rst_n = 1'b1;
    step();

    // Reset mid-RECV, then a single clean sample.
    pulse_start();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    rst_n = 1'b0;
    expect_val(K_ZERO, 64'd0, "reset_mid_recv");
    step();
    rst_n = 1'b1;
    step();
    w.addr = '0;
    w.din  = 24'h123456;
    wq.push_back(w);
    pulse_start();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    expect_val(K_WE, 64'd1, "we_latency");
    step();
    pulse_abort();
    expect_val(K_BUSY,  64'd0, "abort_after_first_busy");
    expect_val(K_COUNT, 64'd1, "abort_after_first_count");

    // Full ramp load, continuous valid; XOR of 6 x (0..255) is 0.
    load_data(0, 1'b0);
`ifdef WAVE_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b0);
`endif
    finish_load(WAVE_DEPTH, 1'b0, "ramp");

    // Same image with random valid gaps.
    load_data(0, 1'b1);
`ifdef WAVE_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b1);
`endif
    finish_load(WAVE_DEPTH, 1'b0, "ramp_gaps");

    // Abort after 100 samples plus one byte; a start mid-load must be ignored.
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      if (i == 50) pulse_start();
      send_sample(0, i, 1'b0);
    end
    send_byte(pay(0, 300), 1'b0);
    pulse_abort();
    expect_val(K_BUSY,  64'd0,            "abort100_busy");
    expect_val(K_COUNT, 64'd100,          "abort100_count");
    expect_val(K_DONES, 64'(exp_dones),   "abort100_no_done");
    bus.byte_valid_in = 1'b1;
    repeat (5) step();
    bus.byte_valid_in = 1'b0;
    expect_val(K_COUNT, 64'd100,          "abort100_count_hold");

`ifdef WAVE_LOADER_CHECKSUM_EN
    // All-0xAA payload: good checksum, then bad checksum, then error cleared by start.
    load_data(1, 1'b0);
    send_byte(8'h00, 1'b0);
    finish_load(WAVE_DEPTH, 1'b0, "csum_good");
    load_data(1, 1'b0);
    send_byte(8'h01, 1'b0);
    finish_load(WAVE_DEPTH, 1'b1, "csum_bad");
    pulse_start();
    expect_val(K_ERR, 64'd0, "csum_err_cleared");
    pulse_abort();
`endif

    // Abort during the WRITE of index 7.
    pulse_start();
    for (int i = 0; i < 8; i++) send_sample(0, i, 1'b0);
    pulse_abort();
    expect_val(K_BUSY,  64'd0,          "abort_write_busy");
    expect_val(K_COUNT, 64'd8,          "abort_write_count");
    expect_val(K_DONES, 64'(exp_dones), "abort_write_no_done");

    // Start and abort together while idle: start wins.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    expect_val(K_BUSY,  64'd1, "start_beats_abort");
    expect_val(K_COUNT, 64'd0, "start_clears_count");
    pulse_abort();
    expect_val(K_BUSY,  64'd0, "final_idle");

    expect_val(K_PENDING, 64'd0, "writes_outstanding");
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
